// File: rtl/rbi_mem_l2_arb_pkg.sv
// Shared types and ring opcode values for the two-requester L2 ring scheduler.
// The opcode values mirror ringbus/RbiDefs.v so this slice is self-contained.
package rbi_mem_l2_arb_pkg;

  localparam logic [15:0] JX2_RBI_OPM_IDLE = 16'h0000;
  localparam logic [7:0]  JX2_RBI_OPM_LDX  = 8'h93;
  localparam logic [7:0]  JX2_RBI_OPM_STX  = 8'hA3;
  localparam logic [7:0]  JX2_RBI_OPM_OKLD = 8'h63;
  localparam logic [7:0]  JX2_RBI_OPM_OKST = 8'h73;

  // opm[7:6] of every OK* response opcode
  localparam logic [1:0]  RBI_RESP_CLASS   = 2'b01;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_WAIT_SLOT,
    PORT_WAIT_RESP
  } portState_t;

  typedef enum logic {
    RR_A,
    RR_B
  } rrSide_t;

  typedef struct packed {
    logic [15:0]  seq;
    logic [15:0]  opm;
    logic [47:0]  addr;
    logic [127:0] data;
  } ringSlot_t;

  localparam ringSlot_t IDLE_SLOT = '{seq: '0, opm: JX2_RBI_OPM_IDLE, addr: '0, data: '0};

  function automatic logic isNodeResp(input logic [15:0] opm, input logic [15:0] seq,
                                      input logic [7:0] nodeId);
    return (opm[7:6] == RBI_RESP_CLASS) && (seq[15:8] == nodeId);
  endfunction

  function automatic ringSlot_t makeReq(input logic [7:0] nodeId, input logic idx,
                                        input logic [2:0] gen, input logic isStore,
                                        input logic [47:0] addr, input logic [127:0] data);
    ringSlot_t s;
    s.opm  = {8'h00, isStore ? JX2_RBI_OPM_STX : JX2_RBI_OPM_LDX};
    s.seq  = {nodeId, 4'h0, idx, gen};
    s.addr = addr;
    s.data = isStore ? data : '0;
    return s;
  endfunction

endpackage

// File: rtl/rbi_mem_l2_arb_if.sv
// Ring slot fields plus both local requester channels of the L2 ring scheduler.
interface rbi_mem_l2_arb_if;

  logic [15:0]  memSeqIn,  memSeqOut;
  logic [15:0]  memOpmIn,  memOpmOut;
  logic [47:0]  memAddrIn, memAddrOut;
  logic [127:0] memDataIn, memDataOut;

  logic         reqValidA, reqValidB;
  logic         reqStA,    reqStB;
  logic [47:0]  reqAddrA,  reqAddrB;
  logic [127:0] reqDataA,  reqDataB;
  logic         reqOkA,    reqOkB;
  logic         respValidA, respValidB;
  logic         respErrA,  respErrB;
  logic [127:0] respDataA, respDataB;

  modport master (
    output memSeqIn, memOpmIn, memAddrIn, memDataIn,
    output reqValidA, reqValidB, reqStA, reqStB, reqAddrA, reqAddrB, reqDataA, reqDataB,
    input  memSeqOut, memOpmOut, memAddrOut, memDataOut,
    input  reqOkA, reqOkB, respValidA, respValidB, respErrA, respErrB, respDataA, respDataB
  );

  modport slave (
    input  memSeqIn, memOpmIn, memAddrIn, memDataIn,
    input  reqValidA, reqValidB, reqStA, reqStB, reqAddrA, reqAddrB, reqDataA, reqDataB,
    output memSeqOut, memOpmOut, memAddrOut, memDataOut,
    output reqOkA, reqOkB, respValidA, respValidB, respErrA, respErrB, respDataA, respDataB
  );

endinterface

// File: rtl/rbi_mem_l2_arb_port.sv
// One local requester: request FSM, sequence generation, response timeout and
// response data latch.
module rbi_mem_l2_arb_port
  import rbi_mem_l2_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023,
  parameter logic        IDX     = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         reqValid,
  input  logic         grant,
  input  logic         respHit,
  input  logic [3:0]   respSeq,
  input  logic [127:0] respDataIn,
  output logic         waiting,
  output logic [2:0]   gen,
  output logic         reqOk,
  output logic         respValid,
  output logic         respErr,
  output logic [127:0] respData
);

  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  portState_t  state, stateNext;
  logic [2:0]  pendGen;
  logic [9:0]  toCount;
  logic        matched, timedOut;

  assign waiting  = (state == PORT_WAIT_SLOT) && reqValid;
  assign matched  = (state == PORT_WAIT_RESP) && respHit &&
                    (respSeq[3] == IDX) && (respSeq[2:0] == pendGen);
  // A response arriving on the final count still counts as a success.
  assign timedOut = (state == PORT_WAIT_RESP) && (toCount == TO_LAST) && !matched;

  always_comb begin
    stateNext = state;
    case (state)
      PORT_IDLE:      if (reqValid) stateNext = PORT_WAIT_SLOT;
      PORT_WAIT_SLOT: begin
        if (grant)          stateNext = PORT_WAIT_RESP;
        else if (!reqValid) stateNext = PORT_IDLE;
      end
      PORT_WAIT_RESP: if (matched || timedOut) stateNext = PORT_IDLE;
      default:        stateNext = PORT_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= PORT_IDLE;
      gen       <= '0;
      pendGen   <= '0;
      toCount   <= '0;
      reqOk     <= 1'b0;
      respValid <= 1'b0;
      respErr   <= 1'b0;
      respData  <= '0;
    end else begin
      state     <= stateNext;
      reqOk     <= grant;
      respValid <= matched || timedOut;
      respErr   <= timedOut;
      if (grant) begin
        pendGen <= gen;
        gen     <= gen + 3'd1;
        toCount <= '0;
      end else if (state == PORT_WAIT_RESP) begin
        toCount <= toCount + 10'd1;
      end
      if (matched) respData <= respDataIn;
    end
  end

endmodule

// File: rtl/rbi_mem_l2_arb.sv
// RBI ring node sharing the L2 tile between two local masters: one-stage ring
// register, response consumption, slot injection and round-robin arbitration.
module rbi_mem_l2_arb
  import rbi_mem_l2_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            unitNodeId,
  rbi_mem_l2_arb_if.slave       bus
);

  ringSlot_t   slotIn, slotOut, slotNext;
  rrSide_t     rrPtr;
  logic        recognized, freeSlot;
  logic        waitA, waitB, grantA, grantB;
  logic [2:0]  genA, genB;

  assign slotIn = '{seq: bus.memSeqIn, opm: bus.memOpmIn,
                    addr: bus.memAddrIn, data: bus.memDataIn};

  // Any response addressed to this node is retired, matched or stale.
  assign recognized = isNodeResp(bus.memOpmIn, bus.memSeqIn, unitNodeId);
  assign freeSlot   = (bus.memOpmIn == JX2_RBI_OPM_IDLE) || recognized;

  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (freeSlot) begin
      if (waitA && waitB) begin
        grantA = (rrPtr == RR_A);
        grantB = (rrPtr == RR_B);
      end else begin
        grantA = waitA;
        grantB = waitB;
      end
    end
  end

  always_comb begin
    slotNext = slotIn;
    if (recognized) slotNext = IDLE_SLOT;
    if (grantA)
      slotNext = makeReq(unitNodeId, 1'b0, genA, bus.reqStA, bus.reqAddrA, bus.reqDataA);
    else if (grantB)
      slotNext = makeReq(unitNodeId, 1'b1, genB, bus.reqStB, bus.reqAddrB, bus.reqDataB);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slotOut <= IDLE_SLOT;
      rrPtr   <= RR_A;
    end else begin
      slotOut <= slotNext;
      if (freeSlot && waitA && waitB)
        rrPtr <= (rrPtr == RR_A) ? RR_B : RR_A;
    end
  end

  assign bus.memSeqOut  = slotOut.seq;
  assign bus.memOpmOut  = slotOut.opm;
  assign bus.memAddrOut = slotOut.addr;
  assign bus.memDataOut = slotOut.data;

  rbi_mem_l2_arb_port #(.TIMEOUT(TIMEOUT), .IDX(1'b0)) portA (
    .clock      (clock),
    .reset      (reset),
    .reqValid   (bus.reqValidA),
    .grant      (grantA),
    .respHit    (recognized),
    .respSeq    (bus.memSeqIn[3:0]),
    .respDataIn (bus.memDataIn),
    .waiting    (waitA),
    .gen        (genA),
    .reqOk      (bus.reqOkA),
    .respValid  (bus.respValidA),
    .respErr    (bus.respErrA),
    .respData   (bus.respDataA)
  );

  rbi_mem_l2_arb_port #(.TIMEOUT(TIMEOUT), .IDX(1'b1)) portB (
    .clock      (clock),
    .reset      (reset),
    .reqValid   (bus.reqValidB),
    .grant      (grantB),
    .respHit    (recognized),
    .respSeq    (bus.memSeqIn[3:0]),
    .respDataIn (bus.memDataIn),
    .waiting    (waitB),
    .gen        (genB),
    .reqOk      (bus.reqOkB),
    .respValid  (bus.respValidB),
    .respErr    (bus.respErrB),
    .respData   (bus.respDataB)
  );

endmodule

// File: tb/tb_rbi_mem_l2_arb.sv
// Directed bench for rbi_mem_l2_arb with a scoreboard of expected injections and responses.
module tb_rbi_mem_l2_arb;

  localparam logic [7:0]  NODE     = 8'h5A;
  localparam logic [15:0] OPM_IDLE = 16'h0000;
  localparam logic [15:0] OPM_LDX  = 16'h0093;
  localparam logic [15:0] OPM_STX  = 16'h00A3;
  localparam logic [15:0] OPM_OKLD = 16'h0063;
  localparam logic [15:0] OPM_OKST = 16'h0073;

  typedef struct {
    logic [15:0]  opm;
    logic [15:0]  seq;
    logic [47:0]  addr;
    logic [127:0] data;
  } injExp_t;

  typedef struct {
    logic         err;
    logic [127:0] data;
  } respExp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] unitNodeId;

  always #5 clock = ~clock;

  rbi_mem_l2_arb_if bus();

  rbi_mem_l2_arb #(.TIMEOUT(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .unitNodeId (unitNodeId),
    .bus        (bus)
  );

  injExp_t  injQA[$], injQB[$];
  respExp_t respQA[$], respQB[$];
  int nCmp = 0, nFail = 0;
  int genA = 0, genB = 0;
  logic [127:0] lastA = '0, lastB = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] seqOf(input logic idx, input int gen);
    return {NODE, 4'h0, idx, 3'(gen)};
  endfunction

  task automatic checkSlot(input string tag, input injExp_t e);
    check({tag, ".opm"},  bus.memOpmOut,  e.opm);
    check({tag, ".seq"},  bus.memSeqOut,  e.seq);
    check({tag, ".addr"}, bus.memAddrOut, e.addr);
    check({tag, ".data"}, bus.memDataOut, e.data);
  endtask

  task automatic setRing(input logic [15:0] opm, input logic [15:0] seq,
                         input logic [47:0] addr, input logic [127:0] data);
    bus.memOpmIn  = opm;
    bus.memSeqIn  = seq;
    bus.memAddrIn = addr;
    bus.memDataIn = data;
  endtask

  task automatic setForeign(input int i);
    setRing(OPM_LDX, {8'h33, 8'(i)}, 48'h0000_ABCD_0000 + 48'(i), {4{32'hF00D_0000 + 32'(i)}});
  endtask

  // One clock; every reqOk/respValid pulse is matched against the scoreboard.
  task automatic tick();
    injExp_t  ie;
    respExp_t re;
    @(posedge clock);
    #1;
    if (bus.reqOkA === 1'b1) begin
      check("sbA.injPending", injQA.size() != 0, 1'b1);
      if (injQA.size() != 0) begin ie = injQA.pop_front(); checkSlot("injA", ie); end
    end
    if (bus.reqOkB === 1'b1) begin
      check("sbB.injPending", injQB.size() != 0, 1'b1);
      if (injQB.size() != 0) begin ie = injQB.pop_front(); checkSlot("injB", ie); end
    end
    if (bus.respValidA === 1'b1) begin
      check("sbA.respPending", respQA.size() != 0, 1'b1);
      if (respQA.size() != 0) begin
        re = respQA.pop_front();
        check("respA.err",  bus.respErrA,  re.err);
        check("respA.data", bus.respDataA, re.data);
      end
    end
    if (bus.respValidB === 1'b1) begin
      check("sbB.respPending", respQB.size() != 0, 1'b1);
      if (respQB.size() != 0) begin
        re = respQB.pop_front();
        check("respB.err",  bus.respErrB,  re.err);
        check("respB.data", bus.respDataB, re.data);
      end
    end
  endtask

  task automatic issue(input logic side, input logic st, input logic [47:0] addr,
                       input logic [127:0] data);
    injExp_t e;
    e.opm  = st ? OPM_STX : OPM_LDX;
    e.addr = addr;
    e.data = st ? data : 128'd0;
    if (side) begin
      bus.reqValidB = 1'b1; bus.reqStB = st; bus.reqAddrB = addr; bus.reqDataB = data;
      e.seq = seqOf(1'b1, genB);
      injQB.push_back(e);
      genB = (genB + 1) % 8;
    end else begin
      bus.reqValidA = 1'b1; bus.reqStA = st; bus.reqAddrA = addr; bus.reqDataA = data;
      e.seq = seqOf(1'b0, genA);
      injQA.push_back(e);
      genA = (genA + 1) % 8;
    end
  endtask

  task automatic waitOk(input logic side, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 16) begin
      tick();
      n++;
      seen = side ? bus.reqOkB : bus.reqOkA;
    end
    check(side ? "reqOkB.seen" : "reqOkA.seen", seen, 1'b1);
    if (side) bus.reqValidB = 1'b0; else bus.reqValidA = 1'b0;
  endtask

  task automatic respond(input logic side, input int gen, input logic [127:0] data);
    respExp_t r;
    r.err  = 1'b0;
    r.data = data;
    setRing(side ? OPM_OKST : OPM_OKLD, seqOf(side, gen), 48'h0, data);
    if (side) respQB.push_back(r); else respQA.push_back(r);
    tick();
    check(side ? "respValidB" : "respValidA", side ? bus.respValidB : bus.respValidA, 1'b1);
    check("resp.consumedOpm",  bus.memOpmOut,  OPM_IDLE);
    check("resp.consumedData", bus.memDataOut, 128'd0);
    setRing(OPM_IDLE, 16'h0, 48'h0, 128'd0);
    if (side) lastB = data; else lastA = data;
  endtask

  task automatic checkReset(input string tag);
    check({tag, ".opm"},   bus.memOpmOut,  OPM_IDLE);
    check({tag, ".seq"},   bus.memSeqOut,  16'h0);
    check({tag, ".addr"},  bus.memAddrOut, 48'h0);
    check({tag, ".data"},  bus.memDataOut, 128'd0);
    check({tag, ".ok"},    {bus.reqOkA, bus.reqOkB}, 2'b00);
    check({tag, ".valid"}, {bus.respValidA, bus.respValidB}, 2'b00);
    check({tag, ".err"},   {bus.respErrA, bus.respErrB}, 2'b00);
    check({tag, ".dataA"}, bus.respDataA, 128'd0);
    check({tag, ".dataB"}, bus.respDataB, 128'd0);
  endtask

  initial begin
    int n;
    respExp_t r;
    reset = 1'b0;
    unitNodeId = NODE;
    setRing(OPM_IDLE, 16'h0, 48'h0, 128'd0);
    bus.reqValidA = 1'b0; bus.reqStA = 1'b0; bus.reqAddrA = '0; bus.reqDataA = '0;
    bus.reqValidB = 1'b0; bus.reqStB = 1'b0; bus.reqAddrB = '0; bus.reqDataB = '0;
    repeat (3) tick();
    checkReset("rst");
    reset = 1'b1;
    tick();

    // Single load, idle ring: 2-cycle reqOk latency, then matched OKLD.
    issue(1'b0, 1'b0, 48'h0000_0000_8010, 128'hDEAD_BEEF);
    waitOk(1'b0, n);
    check("lat.reqOkA", n, 2);
    respond(1'b0, 0, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321);

    // Contention: A wins first, then B wins the repeat.
    issue(1'b0, 1'b0, 48'h0000_0000_9000, 128'd0);
    issue(1'b1, 1'b1, 48'h0000_1000_0040, 128'hB1B1_0000_0000_0000_0000_0000_0000_B1B1);
    tick();
    tick();
    check("rr1.first", {bus.reqOkA, bus.reqOkB}, 2'b10);
    bus.reqValidA = 1'b0;
    tick();
    check("rr1.second", {bus.reqOkA, bus.reqOkB}, 2'b01);
    bus.reqValidB = 1'b0;
    respond(1'b0, 1, 128'hA2A2_0000_0000_0000_0000_0000_0000_A2A2);
    respond(1'b1, 0, 128'hB0B0_0000_0000_0000_0000_0000_0000_0001);
    issue(1'b0, 1'b0, 48'h0000_0000_9100, 128'd0);
    issue(1'b1, 1'b1, 48'h0000_1000_0080, 128'hB2B2_0000_0000_0000_0000_0000_0000_B2B2);
    tick();
    tick();
    check("rr2.first", {bus.reqOkA, bus.reqOkB}, 2'b01);
    bus.reqValidB = 1'b0;
    tick();
    check("rr2.second", {bus.reqOkA, bus.reqOkB}, 2'b10);
    bus.reqValidA = 1'b0;
    respond(1'b0, 2, 128'hA3A3_0000_0000_0000_0000_0000_0000_A3A3);
    respond(1'b1, 1, 128'hB0B0_0000_0000_0000_0000_0000_0000_0002);

    // Cancel before grant: no reqOk, no generation consumed.
    setForeign(99);
    bus.reqValidA = 1'b1;
    tick();
    bus.reqValidA = 1'b0;
    tick();
    setRing(OPM_IDLE, 16'h0, 48'h0, 128'd0);
    tick();
    tick();
    check("cancel.noOk", bus.reqOkA, 1'b0);

    // Busy ring: foreign slots forwarded untouched, grant on first idle slot.
    issue(1'b0, 1'b0, 48'h0000_0000_A000, 128'd0);
    for (int i = 0; i < 20; i++) begin
      setForeign(i);
      tick();
      check("busy.noOk", bus.reqOkA, 1'b0);
      check("busy.fwd", {bus.memOpmOut, bus.memSeqOut, bus.memAddrOut},
            {OPM_LDX, 8'h33, 8'(i), 48'h0000_ABCD_0000 + 48'(i)});
    end
    setRing(OPM_IDLE, 16'h0, 48'h0, 128'd0);
    tick();
    check("busy.grant", bus.reqOkA, 1'b1);
    bus.reqValidA = 1'b0;

    // Timeout at TIMEOUT=8 cycles after reqOk, data held; late response is stale.
    r.err = 1'b1;
    r.data = lastA;
    respQA.push_back(r);
    n = 0;
    while (bus.respValidA !== 1'b1 && n < 20) begin tick(); n++; end
    check("timeout.latency", n, 8);
    setRing(OPM_OKLD, seqOf(1'b0, 3), 48'h0, 128'hBAD0);
    tick();
    check("late.consumed", bus.memOpmOut, OPM_IDLE);
    check("late.noResp", bus.respValidA, 1'b0);

    // Stale response slot reused by B's store in the same cycle.
    setForeign(50);
    issue(1'b1, 1'b1, 48'h0000_2000_0000, 128'hB3B3_0000_0000_0000_0000_0000_0000_B3B3);
    tick();
    tick();
    check("reuse.wait", bus.reqOkB, 1'b0);
    setRing(OPM_OKLD, seqOf(1'b0, 7), 48'h0, 128'hBAD1);
    tick();
    check("reuse.grant", bus.reqOkB, 1'b1);
    check("reuse.noRespA", bus.respValidA, 1'b0);
    bus.reqValidB = 1'b0;
    setRing(OPM_IDLE, 16'h0, 48'h0, 128'd0);
    respond(1'b1, 2, 128'hB0B0_0000_0000_0000_0000_0000_0000_0003);

    // Walk B's generation through the 7 -> 0 wrap.
    for (int k = 0; k < 6; k++) begin
      issue(1'b1, 1'b0, 48'h0000_3000_0000 + 48'(k), 128'd0);
      waitOk(1'b1, n);
      respond(1'b1, (3 + k) % 8, 128'hC0DE_0000 + 128'(k));
    end

    // Reset with A in WAIT_RESP: everything forgotten, later response stale.
    issue(1'b0, 1'b0, 48'h0000_0000_B000, 128'd0);
    waitOk(1'b0, n);
    reset = 1'b0;
    #1;
    checkReset("midRst");
    tick();
    reset = 1'b1;
    genA = 0;
    genB = 0;
    tick();
    setRing(OPM_OKLD, seqOf(1'b0, 4), 48'h0, 128'hBAD2);
    tick();
    check("postRst.consumed", bus.memOpmOut, OPM_IDLE);
    check("postRst.noResp", bus.respValidA, 1'b0);
    setRing(OPM_IDLE, 16'h0, 48'h0, 128'd0);
    tick();

    check("sb.leftover", injQA.size() + injQB.size() + respQA.size() + respQB.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
